// File: rtl/mobo_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mobo_mem_ctrl_if
// Brief    : CPU-to-motherboard memory bus. The CPU side (master) drives the
//            command, address and write data. The controller side (slave)
//            returns status and read data.
// Revision : 1.0 - initial release
// ============================================================================
interface mobo_mem_ctrl_if #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic [WORD_WIDTH-1:0] mobo_ctrl;
  logic [ADDR_WIDTH-1:0] mobo_addr;
  logic [WORD_WIDTH-1:0] mobo_wdata;
  logic [WORD_WIDTH-1:0] mobo_stat;
  logic [WORD_WIDTH-1:0] mobo_rdata;

  modport master (
    output mobo_ctrl, mobo_addr, mobo_wdata,
    input  mobo_stat, mobo_rdata
  );

  modport slave (
    input  mobo_ctrl, mobo_addr, mobo_wdata,
    output mobo_stat, mobo_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mobo_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mobo_mem_ctrl
// Brief    : Single-access memory controller. It takes one READ or WRITE
//            command from the CPU and performs it on an internal word array
//            after ACCESS_LAT busy cycles. Progress is reported on mobo_stat.
//            Optional macro MOBO_MEM_BOUNDS_EN: addresses >= MEM_DEPTH are
//            rejected with STAT_ERR. Without it, addresses wrap modulo
//            MEM_DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module mobo_mem_ctrl #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_DEPTH  = 1024,
  parameter int ACCESS_LAT = 2
) (
  input  wire               clk,
  input  wire               rst,
  mobo_mem_ctrl_if.slave    bus
);

  // Command and status codes shared with the CPU function states
  localparam logic [WORD_WIDTH-1:0] CTRL_NONE  = WORD_WIDTH'(0);
  localparam logic [WORD_WIDTH-1:0] CTRL_READ  = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] CTRL_WRITE = WORD_WIDTH'(2);
  localparam logic [WORD_WIDTH-1:0] STAT_IDLE  = WORD_WIDTH'(0);
  localparam logic [WORD_WIDTH-1:0] STAT_BUSY  = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] STAT_DONE  = WORD_WIDTH'(2);
`ifdef MOBO_MEM_BOUNDS_EN
  localparam logic [WORD_WIDTH-1:0] STAT_ERR   = WORD_WIDTH'(3);
`endif

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
`ifdef MOBO_MEM_BOUNDS_EN
    ,
    S_ERR  = 2'd3
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] stat_q, stat_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mem_we;

  logic [WORD_WIDTH-1:0] mem [MEM_DEPTH];

  // Latched address, widened so it compares and reduces cleanly against MEM_DEPTH
  logic [31:0]           addr_ext;
  logic [IDX_W-1:0]      mem_idx;
  assign addr_ext = 32'(addr_q);
  assign mem_idx  = IDX_W'(addr_ext % 32'(MEM_DEPTH));

`ifdef MOBO_MEM_BOUNDS_EN
  logic addr_in_range;
  assign addr_in_range = (addr_ext < 32'(MEM_DEPTH));
`endif

  // Next-state logic: accept, count down, commit, then wait for the CPU to release
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_we     = 1'b0;
    stat_d     = STAT_IDLE;

    case (state_q)
      S_IDLE: begin
        if (bus.mobo_ctrl == CTRL_READ || bus.mobo_ctrl == CTRL_WRITE) begin
          op_write_d = (bus.mobo_ctrl == CTRL_WRITE);
          addr_d     = bus.mobo_addr;
          wdata_d    = bus.mobo_wdata;
          cnt_d      = CNT_W'(ACCESS_LAT - 1);
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
`ifdef MOBO_MEM_BOUNDS_EN
          if (!addr_in_range) begin
            state_d = S_ERR;
          end else
`endif
          begin
            if (op_write_q) begin
              mem_we = 1'b1;
            end else begin
              rdata_d = mem[mem_idx];
            end
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A command left asserted must not start a second access
        if (bus.mobo_ctrl == CTRL_NONE) state_d = S_IDLE;
      end
`ifdef MOBO_MEM_BOUNDS_EN
      S_ERR: begin
        if (bus.mobo_ctrl == CTRL_NONE) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Status is registered and always mirrors the state being entered
    case (state_d)
      S_BUSY:  stat_d = STAT_BUSY;
      S_DONE:  stat_d = STAT_DONE;
`ifdef MOBO_MEM_BOUNDS_EN
      S_ERR:   stat_d = STAT_ERR;
`endif
      default: stat_d = STAT_IDLE;
    endcase
  end

  // Control and data registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      stat_q     <= STAT_IDLE;
      rdata_q    <= '0;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      stat_q     <= stat_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Array write port. Contents survive reset. A reset on the commit edge cancels the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  assign bus.mobo_stat  = stat_q;
  assign bus.mobo_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mobo_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mobo_mem_ctrl
// Brief    : Directed self-checking bench for mobo_mem_ctrl (small array so
//            that out-of-range addresses can be driven).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mobo_mem_ctrl;

  localparam int W     = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  localparam logic [W-1:0] C_NONE  = 16'd0;
  localparam logic [W-1:0] C_READ  = 16'd1;
  localparam logic [W-1:0] C_WRITE = 16'd2;
  localparam logic [W-1:0] S_IDLE  = 16'd0;
  localparam logic [W-1:0] S_BUSY  = 16'd1;
  localparam logic [W-1:0] S_DONE  = 16'd2;
  localparam logic [W-1:0] S_ERR   = 16'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [W-1:0] exp_rdata;

  mobo_mem_ctrl_if #(.WORD_WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  mobo_mem_ctrl #(
    .WORD_WIDTH(W), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .ACCESS_LAT(LAT)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a command and follow it through LAT busy cycles to its final status.
  task automatic issue(input logic [W-1:0] op, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] fin, input string tag);
    bus.mobo_ctrl  = op;
    bus.mobo_addr  = a;
    bus.mobo_wdata = d;
    for (int i = 0; i < LAT; i++) begin
      tick();
      check({tag, "_busy"}, bus.mobo_stat, S_BUSY);
    end
    tick();
    check({tag, "_fin"}, bus.mobo_stat, fin);
  endtask

  task automatic release_cmd(input string tag);
    bus.mobo_ctrl = C_NONE;
    tick();
    check({tag, "_idle"}, bus.mobo_stat, S_IDLE);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input string tag);
    issue(C_WRITE, a, d, S_DONE, tag);
    check({tag, "_rdata_kept"}, bus.mobo_rdata, exp_rdata);
    release_cmd(tag);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] d, input string tag);
    issue(C_READ, a, '0, S_DONE, tag);
    exp_rdata = d;
    check({tag, "_rdata"}, bus.mobo_rdata, d);
    release_cmd(tag);
  endtask

  initial begin
    bus.mobo_ctrl  = C_READ;
    bus.mobo_addr  = '0;
    bus.mobo_wdata = '0;
    exp_rdata      = '0;

    // Reset held three cycles with READ asserted: never BUSY
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_stat", bus.mobo_stat, S_IDLE);
    end
    check("rst_rdata", bus.mobo_rdata, 16'h0000);
    bus.mobo_ctrl = C_NONE;
    rst = 1'b0;
    tick();
    check("post_rst_stat", bus.mobo_stat, S_IDLE);

    // Write then read back address 5
    wr(6'd5, 16'h00A5, "wr5");
    rd(6'd5, 16'h00A5, "rd5");

    // READ held after DONE: stays DONE, no retrigger
    wr(6'd6, 16'h0066, "wr6");
    issue(C_READ, 6'd6, '0, S_DONE, "hold");
    exp_rdata = 16'h0066;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_done", bus.mobo_stat, S_DONE);
    end
    release_cmd("hold");
    tick();
    check("hold_no_retrig", bus.mobo_stat, S_IDLE);
    check("hold_rdata", bus.mobo_rdata, 16'h0066);

    // Inputs changed during BUSY are ignored
    wr(6'd9, 16'h0099, "wr9");
    bus.mobo_ctrl  = C_WRITE;
    bus.mobo_addr  = 6'd7;
    bus.mobo_wdata = 16'h0077;
    tick();
    check("chg_busy", bus.mobo_stat, S_BUSY);
    bus.mobo_addr  = 6'd9;
    bus.mobo_wdata = 16'hFFFF;
    tick();
    tick();
    check("chg_done", bus.mobo_stat, S_DONE);
    release_cmd("chg");
    rd(6'd7, 16'h0077, "rd7");
    rd(6'd9, 16'h0099, "rd9");

    // Reset on the first BUSY cycle aborts the write
    wr(6'd3, 16'h0022, "wr3");
    bus.mobo_ctrl  = C_WRITE;
    bus.mobo_addr  = 6'd3;
    bus.mobo_wdata = 16'h0011;
    tick();
    check("abort1_busy", bus.mobo_stat, S_BUSY);
    rst = 1'b1;
    bus.mobo_ctrl = C_NONE;
    tick();
    rst = 1'b0;
    check("abort1_idle", bus.mobo_stat, S_IDLE);
    check("abort1_rdata", bus.mobo_rdata, 16'h0000);
    exp_rdata = '0;
    rd(6'd3, 16'h0022, "abort1_rd3");

    // Reset on the commit edge also cancels the write
    bus.mobo_ctrl  = C_WRITE;
    bus.mobo_addr  = 6'd3;
    bus.mobo_wdata = 16'h0033;
    tick();
    tick();
    check("abort2_busy", bus.mobo_stat, S_BUSY);
    rst = 1'b1;
    bus.mobo_ctrl = C_NONE;
    tick();
    rst = 1'b0;
    check("abort2_idle", bus.mobo_stat, S_IDLE);
    exp_rdata = '0;
    rd(6'd3, 16'h0022, "abort2_rd3");

    // Out-of-range address
    wr(6'd1, 16'h1111, "wr1");
    rd(6'd2, 16'hXXXX, "rd2_unwritten");
    wr(6'd2, 16'h2222, "wr2");
    rd(6'd2, 16'h2222, "rd2");
`ifdef MOBO_MEM_BOUNDS_EN
    issue(C_READ, 6'(DEPTH + 1), '0, S_ERR, "oor_rd");
    check("oor_rd_rdata", bus.mobo_rdata, 16'h2222);
    release_cmd("oor_rd");
    issue(C_WRITE, 6'(DEPTH + 1), 16'h0BAD, S_ERR, "oor_wr");
    release_cmd("oor_wr");
    rd(6'd1, 16'h1111, "oor_rd1");
`else
    rd(6'(DEPTH + 1), 16'h1111, "wrap_rd");
    wr(6'(DEPTH + 1), 16'h0BAD, "wrap_wr");
    rd(6'd1, 16'h0BAD, "wrap_rd1");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
